// File: rtl/param_serializer.sv
// param_serializer: parallel-to-serial shifter for the UART TX path.
// One-word holding buffer (HOLD) feeds the shift register so words stream
// back-to-back. Ser_Enable advances one bit. Width and bit order are parametrised.
// Optional feature macro: SER_PARITY_EN adds a parity bit after the data bits
// and the Par_Type port (0 even, 1 odd).
`timescale 1ns/1ps

module param_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter bit LSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_Data,
  input  logic                  Data_Valid,
  output logic                  Ready,
  input  logic                  Ser_Enable,
  output logic                  Ser_Data,
  output logic                  Ser_Done,
  output logic                  Busy
`ifdef SER_PARITY_EN
  ,
  input  logic                  Par_Type
`endif
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  // Bit that goes on the line first when a word is loaded.
  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[DATA_WIDTH-1];
  endfunction

  // Bit that becomes current after the word is advanced by one position.
  function automatic logic next_bit(input logic [DATA_WIDTH-1:0] w);
    return LSB_FIRST ? w[1] : w[DATA_WIDTH-2];
  endfunction

  // Advance the word one position toward the output end.
  function automatic logic [DATA_WIDTH-1:0] shift_word(input logic [DATA_WIDTH-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  // Stage 0: holding buffer
  logic [DATA_WIDTH-1:0] hold_p0;
  logic                  vld_p0;

  // Stage 1: shift register and bit counter
  logic [DATA_WIDTH-1:0] shreg_p1;
  logic [CNT_W-1:0]      cnt_p1;
  state_t                state_p1;
`ifdef SER_PARITY_EN
  logic                  par_p1;
  logic                  to_parity;
`endif

  logic load;
  logic word_end;
  logic shift_step;

  assign Ready = ~vld_p0;

  // Decode what the current strobe does and whether HOLD moves into the shifter.
  always_comb begin
    shift_step = 1'b0;
    word_end   = 1'b0;
`ifdef SER_PARITY_EN
    to_parity  = 1'b0;
`endif
    if (Ser_Enable) begin
      case (state_p1)
        ST_SHIFT: begin
          if (cnt_p1 != LAST) shift_step = 1'b1;
`ifdef SER_PARITY_EN
          else to_parity = 1'b1;
`else
          else word_end = 1'b1;
`endif
        end
        ST_PARITY: word_end = 1'b1;
        default: ;
      endcase
    end
    // A finished word is replaced on the same edge when HOLD has one waiting.
    load = vld_p0 && ((state_p1 == ST_IDLE) || word_end);
  end

  // Holding buffer: capture on handshake, release when the shifter takes it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hold_p0 <= '0;
      vld_p0  <= 1'b0;
    end else if (Data_Valid && Ready) begin
      hold_p0 <= P_Data;
      vld_p0  <= 1'b1;
    end else if (load) begin
      vld_p0  <= 1'b0;
    end
  end

  // Shift FSM with registered Ser_Data/Ser_Done/Busy.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_p1 <= ST_IDLE;
      shreg_p1 <= '0;
      cnt_p1   <= '0;
      Ser_Data <= IDLE_LEVEL;
      Ser_Done <= 1'b0;
      Busy     <= 1'b0;
`ifdef SER_PARITY_EN
      par_p1   <= 1'b0;
`endif
    end else begin
      Ser_Done <= word_end;
      if (load) begin
        state_p1 <= ST_SHIFT;
        shreg_p1 <= hold_p0;
        cnt_p1   <= '0;
        Busy     <= 1'b1;
        Ser_Data <= first_bit(hold_p0);
`ifdef SER_PARITY_EN
        par_p1   <= ^hold_p0;
`endif
      end else if (word_end) begin
        state_p1 <= ST_IDLE;
        cnt_p1   <= '0;
        Busy     <= 1'b0;
        Ser_Data <= IDLE_LEVEL;
      end else if (shift_step) begin
        shreg_p1 <= shift_word(shreg_p1);
        cnt_p1   <= cnt_p1 + 1'b1;
        Ser_Data <= next_bit(shreg_p1);
      end
`ifdef SER_PARITY_EN
      else if (to_parity) begin
        state_p1 <= ST_PARITY;
        Ser_Data <= par_p1 ^ Par_Type;
      end
`endif
    end
  end

endmodule

// File: tb/tb_param_serializer.sv
// Bench for param_serializer: three instances (8-bit LSB-first, 8-bit
// MSB-first, 5-bit LSB-first) driven with directed words.
`timescale 1ns/1ps

module tb_param_serializer;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] pd [2];
  logic [4:0] pd5;
  logic       dv   [3];
  logic       se   [3];
  logic       rdy  [3];
  logic       sd   [3];
  logic       done [3];
  logic       busy [3];
`ifdef SER_PARITY_EN
  logic       par_type = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  param_serializer #(.DATA_WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_lsb (
    .CLK(CLK), .RST(RST), .P_Data(pd[0]), .Data_Valid(dv[0]), .Ready(rdy[0]),
    .Ser_Enable(se[0]), .Ser_Data(sd[0]), .Ser_Done(done[0]), .Busy(busy[0])
`ifdef SER_PARITY_EN
    , .Par_Type(par_type)
`endif
  );

  param_serializer #(.DATA_WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_msb (
    .CLK(CLK), .RST(RST), .P_Data(pd[1]), .Data_Valid(dv[1]), .Ready(rdy[1]),
    .Ser_Enable(se[1]), .Ser_Data(sd[1]), .Ser_Done(done[1]), .Busy(busy[1])
`ifdef SER_PARITY_EN
    , .Par_Type(par_type)
`endif
  );

  param_serializer #(.DATA_WIDTH(5), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_dw5 (
    .CLK(CLK), .RST(RST), .P_Data(pd5), .Data_Valid(dv[2]), .Ready(rdy[2]),
    .Ser_Enable(se[2]), .Ser_Data(sd[2]), .Ser_Done(done[2]), .Busy(busy[2])
`ifdef SER_PARITY_EN
    , .Par_Type(par_type)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a word for one cycle; returns at the negedge after the accept edge.
  task automatic offer(input int idx, input logic [7:0] w);
    if (idx == 2) pd5 = w[4:0];
    else pd[idx] = w;
    dv[idx] = 1'b1;
    @(negedge CLK);
    dv[idx] = 1'b0;
  endtask

  // Starts with bit 0 on the line; strobes once every gap cycles and checks
  // each bit, then the Ser_Done pulse and the line state after the word.
  task automatic send_word(input string name, input int idx, input int n,
                           input logic [31:0] seq, input int gap,
                           input logic more, input logic nxt);
    for (int i = 0; i < n; i++) begin
      repeat (gap - 1) @(negedge CLK);
      check_val($sformatf("%s_bit%0d", name, i), 32'(sd[idx]), 32'(seq[i]));
      check_val($sformatf("%s_busy%0d", name, i), 32'(busy[idx]), 32'd1);
      se[idx] = 1'b1;
      @(negedge CLK);
      se[idx] = 1'b0;
      if (i < n - 1)
        check_val($sformatf("%s_nodone%0d", name, i), 32'(done[idx]), 32'd0);
    end
    check_val({name, "_done"}, 32'(done[idx]), 32'd1);
    check_val({name, "_busy_after"}, 32'(busy[idx]), 32'(more));
    check_val({name, "_line_after"}, 32'(sd[idx]), 32'(more ? nxt : 1'b1));
    @(negedge CLK);
    check_val({name, "_done_pulse"}, 32'(done[idx]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    pd[0] = '0; pd[1] = '0; pd5 = '0;
    for (int k = 0; k < 3; k++) begin
      dv[k] = 1'b0;
      se[k] = 1'b0;
    end

    // Reset state
    @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("rst_ready%0d", k), 32'(rdy[k]), 32'd1);
      check_val($sformatf("rst_busy%0d", k), 32'(busy[k]), 32'd0);
      check_val($sformatf("rst_done%0d", k), 32'(done[k]), 32'd0);
      check_val($sformatf("rst_line%0d", k), 32'(sd[k]), 32'd1);
    end
    RST = 1'b1;
    @(negedge CLK);

`ifdef SER_PARITY_EN
    // Parity: 0x07 even -> parity 1; odd -> parity 0
    par_type = 1'b0;
    offer(0, 8'h07);
    @(negedge CLK);
    send_word("t5_even", 0, 9, 32'h107, 2, 1'b0, 1'b1);
    par_type = 1'b1;
    offer(0, 8'h07);
    @(negedge CLK);
    send_word("t5_odd", 0, 9, 32'h007, 2, 1'b0, 1'b1);
`else
    // Test 1: 0xA5 LSB first, strobe every 4 clocks
    offer(0, 8'hA5);
    check_val("t1_ready_held", 32'(rdy[0]), 32'd0);
    check_val("t1_busy_before_load", 32'(busy[0]), 32'd0);
    @(negedge CLK);
    check_val("t1_ready_after_load", 32'(rdy[0]), 32'd1);
    send_word("t1", 0, 8, 32'h000000A5, 4, 1'b0, 1'b1);

    // Test 2: Ser_Enable tied high, 0x3C then 0xC3 back-to-back
    se[0] = 1'b1;
    pd[0] = 8'h3C;
    dv[0] = 1'b1;
    @(negedge CLK);
    check_val("t2_ready_held", 32'(rdy[0]), 32'd0);
    pd[0] = 8'hC3;
    for (int i = 0; i < 16; i++) begin
      logic [15:0] seq2;
      seq2 = 16'hC33C;
      @(negedge CLK);
      if (i == 1) dv[0] = 1'b0;
      check_val($sformatf("t2_bit%0d", i), 32'(sd[0]), 32'(seq2[i]));
      check_val($sformatf("t2_busy%0d", i), 32'(busy[0]), 32'd1);
      check_val($sformatf("t2_done%0d", i), 32'(done[0]), 32'(i == 8));
    end
    @(negedge CLK);
    se[0] = 1'b0;
    check_val("t2_done_end", 32'(done[0]), 32'd1);
    check_val("t2_busy_end", 32'(busy[0]), 32'd0);
    check_val("t2_line_end", 32'(sd[0]), 32'd1);
    @(negedge CLK);
    check_val("t2_done_pulse", 32'(done[0]), 32'd0);

    // Test 3: MSB first 0x81, 0x42 held, stray 0xFF offered while not ready
    offer(1, 8'h81);
    check_val("t3_ready_held", 32'(rdy[1]), 32'd0);
    @(negedge CLK);
    check_val("t3_busy", 32'(busy[1]), 32'd1);
    offer(1, 8'h42);
    check_val("t3_ready_second", 32'(rdy[1]), 32'd0);
    pd[1] = 8'hFF;
    dv[1] = 1'b1;
    repeat (2) @(negedge CLK);
    dv[1] = 1'b0;
    check_val("t3_ready_still", 32'(rdy[1]), 32'd0);
    send_word("t3_w81", 1, 8, 32'h81, 2, 1'b1, 1'b0);
    check_val("t3_ready_reload", 32'(rdy[1]), 32'd1);
    send_word("t3_w42", 1, 8, 32'h42, 2, 1'b0, 1'b1);

    // Test 4: reset after the third bit of 0xFF with 0x55 held
    offer(0, 8'hFF);
    @(negedge CLK);
    offer(0, 8'h55);
    check_val("t4_ready_held", 32'(rdy[0]), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      se[0] = 1'b1;
      @(negedge CLK);
      se[0] = 1'b0;
    end
    check_val("t4_busy_pre", 32'(busy[0]), 32'd1);
    #2 RST = 1'b0;
    #1;
    check_val("t4_async_line", 32'(sd[0]), 32'd1);
    check_val("t4_async_ready", 32'(rdy[0]), 32'd1);
    check_val("t4_async_busy", 32'(busy[0]), 32'd0);
    check_val("t4_async_done", 32'(done[0]), 32'd0);
    repeat (2) begin
      @(negedge CLK);
      check_val("t4_rst_done", 32'(done[0]), 32'd0);
    end
    RST = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check_val("t4_post_busy", 32'(busy[0]), 32'd0);
      check_val("t4_post_done", 32'(done[0]), 32'd0);
    end
    offer(0, 8'h0F);
    @(negedge CLK);
    send_word("t4_w0F", 0, 8, 32'h0F, 2, 1'b0, 1'b1);

    // Test 6: 5-bit word 0x13 LSB first
    offer(2, 8'h13);
    @(negedge CLK);
    send_word("t6", 2, 5, 32'h13, 3, 1'b0, 1'b1);
`endif

    repeat (2) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
